// File: rtl/cache_pkg.sv
// Shared types for the set-associative write-back cache: FSM states, line metadata,
// default geometry and the derived address-field widths.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_REFILL,
        S_RESP
    } state_t;

    localparam int ADDR_W_D    = 32;
    localparam int DATA_W_D    = 32;
    localparam int WAYS_D      = 2;
    localparam int SETS_D      = 256;
    localparam int BLK_WORDS_D = 4;

    localparam int OFF_W_D = $clog2(BLK_WORDS_D) + 2;
    localparam int IDX_W_D = $clog2(SETS_D);
    localparam int TAG_W_D = ADDR_W_D - OFF_W_D - IDX_W_D;

    // Widest tag any legal geometry can produce; narrower tags are zero-extended.
    localparam int TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
    } line_meta_t;

    // Index widths for vectors that must stay at least one bit wide.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_way_store.sv
// One way of the cache: data words, tags and valid/dirty bits with a single write
// port and combinational reads. Valid/dirty reset to 0; data and tags are not reset.
module cache_way_store
    import cache_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int SETS      = 256,
    parameter int BLK_WORDS = 4,
    parameter int TAG_W     = 20,
    parameter int SET_W     = 8,
    parameter int DIDX_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_dwe,
    input  logic [DIDX_W-1:0] i_didx,
    input  logic [DATA_W-1:0] i_dwdata,
    input  logic [DIDX_W-1:0] i_dridx,
    output logic [DATA_W-1:0] o_drdata,
    input  logic              i_mwe,
    input  logic [SET_W-1:0]  i_mset,
    input  logic              i_mvalid,
    input  logic              i_mdirty,
    input  logic [TAG_W-1:0]  i_mtag,
    output line_meta_t        o_meta
);

    logic [DATA_W-1:0] r_data [SETS*BLK_WORDS];
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;

    always_ff @(posedge clk) begin
        if (i_dwe) r_data[i_didx] <= i_dwdata;
        if (i_mwe) r_tag[i_mset]  <= i_mtag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_mwe) begin
            r_valid[i_mset] <= i_mvalid;
            r_dirty[i_mset] <= i_mdirty;
        end
    end

    assign o_drdata = r_data[i_dridx];

    always_comb begin
        o_meta                = '0;
        o_meta.valid          = r_valid[i_mset];
        o_meta.dirty          = r_dirty[i_mset];
        o_meta.tag[TAG_W-1:0] = r_tag[i_mset];
    end

endmodule

// File: rtl/assoc_wb_cache.sv
// N-way set-associative write-back/write-allocate cache with burst memory handshake.
// Define CACHE_STATS_EN to add saturating hit/miss/write-back counters.
module assoc_wb_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_D,
    parameter int DATA_W    = DATA_W_D,
    parameter int WAYS      = WAYS_D,
    parameter int SETS      = SETS_D,
    parameter int BLK_WORDS = BLK_WORDS_D
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_wbs
`endif
);

    localparam int OFF_W  = $clog2(BLK_WORDS) + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int WORD_W = clog2_min1(BLK_WORDS);
    localparam int SET_W  = clog2_min1(SETS);
    localparam int WAY_W  = clog2_min1(WAYS);
    localparam int DIDX_W = clog2_min1(SETS*BLK_WORDS);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] IDX_MASK = ((ADDR_W'(1) << (OFF_W+IDX_W)) - ADDR_W'(1)) & BLK_MASK;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [WAY_W-1:0]  r_vway;
    logic [TAG_W-1:0]  r_vtag;
    logic [WORD_W-1:0] r_beat;
    logic [WAY_W-1:0]  r_rr [SETS];

    line_meta_t        w_meta  [WAYS];
    logic [DATA_W-1:0] w_rdata [WAYS];
    logic [WAYS-1:0]   w_dwe, w_mwe;
    logic [SET_W-1:0]  w_set;
    logic [TAG_W-1:0]  w_tag, w_mtag;
    logic [DIDX_W-1:0] w_cpu_didx, w_beat_didx, w_didx, w_ridx;
    logic [DATA_W-1:0] w_dwdata;
    logic              w_hit, w_mdirty, w_beat_done, w_last;
    logic [WAY_W-1:0]  w_hway, w_vway;
    logic [ADDR_W-1:0] w_wb_addr, w_rf_addr;

    assign w_set       = (SETS > 1) ? SET_W'(r_addr >> OFF_W) : '0;
    assign w_tag       = TAG_W'(r_addr >> (OFF_W + IDX_W));
    assign w_cpu_didx  = DIDX_W'(r_addr >> 2);
    assign w_beat_didx = DIDX_W'(((r_addr >> OFF_W) << $clog2(BLK_WORDS)) | ADDR_W'(r_beat));
    assign w_ridx      = (r_state == S_WB) ? w_beat_didx : w_cpu_didx;
    assign w_beat_done = mem_req && mem_ready;
    assign w_last      = (r_beat == WORD_W'(BLK_WORDS-1));
    assign w_wb_addr   = (ADDR_W'(r_vtag) << (OFF_W+IDX_W)) | (r_addr & IDX_MASK) | (ADDR_W'(r_beat) << 2);
    assign w_rf_addr   = (r_addr & BLK_MASK) | (ADDR_W'(r_beat) << 2);

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_way_store #(
            .DATA_W(DATA_W), .SETS(SETS), .BLK_WORDS(BLK_WORDS),
            .TAG_W(TAG_W), .SET_W(SET_W), .DIDX_W(DIDX_W)
        ) u_way (
            .clk(clk), .reset(reset),
            .i_dwe(w_dwe[g]), .i_didx(w_didx), .i_dwdata(w_dwdata),
            .i_dridx(w_ridx), .o_drdata(w_rdata[g]),
            .i_mwe(w_mwe[g]), .i_mset(w_set), .i_mvalid(1'b1), .i_mdirty(w_mdirty),
            .i_mtag(w_mtag), .o_meta(w_meta[g])
        );
    end

    // Descending scans so the lowest-numbered matching / invalid way wins.
    always_comb begin
        w_hit  = 1'b0;
        w_hway = '0;
        w_vway = r_rr[w_set];
        for (int w = WAYS-1; w >= 0; w--) begin
            if (w_meta[w].valid && w_meta[w].tag == TAG_MAX_W'(w_tag)) begin
                w_hit  = 1'b1;
                w_hway = WAY_W'(w);
            end
        end
        for (int w = WAYS-1; w >= 0; w--)
            if (!w_meta[w].valid) w_vway = WAY_W'(w);
    end

    always_comb begin
        w_dwe    = '0;
        w_mwe    = '0;
        w_didx   = w_cpu_didx;
        w_dwdata = r_wdata;
        w_mdirty = 1'b1;
        w_mtag   = w_tag;
        case (r_state)
            S_LOOKUP: if (w_hit && r_we) begin
                w_dwe[w_hway] = 1'b1;
                w_mwe[w_hway] = 1'b1;
            end
            S_WB: if (w_beat_done && w_last) begin
                w_mwe[r_vway] = 1'b1;
                w_mdirty      = 1'b0;
                w_mtag        = r_vtag;
            end
            S_REFILL: if (w_beat_done) begin
                w_dwe[r_vway] = 1'b1;
                w_didx        = w_beat_didx;
                w_dwdata      = mem_rdata;
                w_mdirty      = 1'b0;
                w_mwe[r_vway] = w_last;
            end
            S_RESP: if (r_we) begin
                w_dwe[r_vway] = 1'b1;
                w_mwe[r_vway] = 1'b1;
            end
            default: ;
        endcase
    end

    // Each memory beat takes an issue cycle (mem_req rises) then waits for mem_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_vway    <= '0;
            r_vtag    <= '0;
            r_beat    <= '0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
        end else begin
            cpu_done <= 1'b0;
            case (r_state)
                S_IDLE: if (cpu_req) begin
                    r_addr  <= cpu_addr;
                    r_we    <= cpu_we;
                    r_wdata <= cpu_wdata;
                    r_state <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        cpu_done <= 1'b1;
                        if (!r_we) cpu_rdata <= w_rdata[w_hway];
                        r_state <= S_IDLE;
                    end else begin
                        r_vway  <= w_vway;
                        r_vtag  <= w_meta[w_vway].tag[TAG_W-1:0];
                        r_beat  <= '0;
                        r_state <= (w_meta[w_vway].valid && w_meta[w_vway].dirty) ? S_WB : S_REFILL;
                    end
                end
                S_WB: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= w_wb_addr;
                        mem_wdata <= w_rdata[r_vway];
                    end else if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        r_beat  <= w_last ? '0 : r_beat + 1'b1;
                        if (w_last) r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= w_rf_addr;
                    end else if (mem_ready) begin
                        mem_req <= 1'b0;
                        r_beat  <= w_last ? '0 : r_beat + 1'b1;
                        if (w_last) begin
                            r_rr[w_set] <= (r_rr[w_set] == WAY_W'(WAYS-1)) ? '0 : r_rr[w_set] + 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    cpu_done <= 1'b1;
                    if (!r_we) cpu_rdata <= w_rdata[r_vway];
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbs    <= '0;
        end else begin
            if (r_state == S_LOOKUP && w_hit && stat_hits != '1)    stat_hits   <= stat_hits + 1'b1;
            if (r_state == S_LOOKUP && !w_hit && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
            if (r_state == S_WB && w_beat_done && w_last && stat_wbs != '1) stat_wbs <= stat_wbs + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Directed bench for assoc_wb_cache: refill, hit latency, write-back, stalls and mid-burst reset.
// Memory model returns word = address unless a write-back stored other data.
module tb_assoc_wb_cache;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_done, mem_req, mem_we, mem_ready;
`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses, stat_wbs;
`endif

    assoc_wb_cache dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbs(stat_wbs)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: one-cycle ready per beat unless held off.
    logic        hold = 1'b0;
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        log_we   [$];

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && !hold && !reset) begin
                mem_ready = 1'b1;
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
                if (mem_we) begin
                    mem_model[mem_addr] = mem_wdata;
                    log_data.push_back(mem_wdata);
                end else begin
                    mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : mem_addr;
                    log_data.push_back(mem_rdata);
                end
            end else begin
                mem_ready = 1'b0;
            end
        end
    end

    int          done_cnt = 0, done_edge = 0, dbl_done = 0;
    logic [31:0] done_rdata = '0;
    logic        prev_done = 1'b0;
    always @(negedge clk) begin
        if (cpu_done === 1'b1) begin
            done_cnt++;
            done_rdata = cpu_rdata;
            done_edge  = cyc + 1;
            if (prev_done) dbl_done++;
        end
        prev_done = (cpu_done === 1'b1);
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_we.delete();
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, output int acc_edge);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        acc_edge = cyc + 1;
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic wait_done(input int n0, output logic ok);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (done_cnt > n0) break;
        end
        ok = (done_cnt > n0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_req !== 1'b0)  begin fails++; $display("FAIL rst_mem_req: got %b exp 0", mem_req); end
        checks++; if (mem_we !== 1'b0)   begin fails++; $display("FAIL rst_mem_we: got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_mem_wdata: got %h exp 0", mem_wdata); end
        checks++; if (cpu_done !== 1'b0) begin fails++; $display("FAIL rst_cpu_done: got %b exp 0", cpu_done); end
        checks++; if (cpu_rdata !== 32'h0) begin fails++; $display("FAIL rst_cpu_rdata: got %h exp 0", cpu_rdata); end
`ifdef CACHE_STATS_EN
        checks++; if ({stat_hits, stat_misses, stat_wbs} !== 96'h0) begin fails++; $display("FAIL rst_stats: got %h exp 0", {stat_hits, stat_misses, stat_wbs}); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_refill_read();
        int acc, n0; logic ok;
        clear_log();
        n0 = done_cnt;
        issue(1'b0, 32'h1000, 32'h0, acc);
        wait_done(n0, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL refill_timeout: got %b exp 1", ok); end
        checks++; if (done_rdata !== 32'h1000) begin fails++; $display("FAIL refill_rdata: got %h exp %h", done_rdata, 32'h1000); end
        checks++; if (log_addr.size() !== 4) begin fails++; $display("FAIL refill_beats: got %0d exp 4", log_addr.size()); end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            checks++; if (log_addr[i] !== 32'h1000 + 32'(4*i) || log_we[i] !== 1'b0) begin
                fails++; $display("FAIL refill_beat%0d: got %h we=%b exp %h we=0", i, log_addr[i], log_we[i], 32'h1000 + 32'(4*i));
            end
        end
        repeat (4) @(posedge clk);
        checks++; if (done_cnt !== n0 + 1) begin fails++; $display("FAIL refill_done_once: got %0d exp %0d", done_cnt - n0, 1); end
    endtask

    task automatic test_hit();
        int acc, n0; logic ok;
        clear_log();
        n0 = done_cnt;
        issue(1'b0, 32'h1004, 32'h0, acc);
        wait_done(n0, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL hit_timeout: got %b exp 1", ok); end
        checks++; if (done_rdata !== 32'h1004) begin fails++; $display("FAIL hit_rdata: got %h exp %h", done_rdata, 32'h1004); end
        checks++; if (done_edge - acc !== 2) begin fails++; $display("FAIL hit_latency: got %0d exp 2", done_edge - acc); end
        checks++; if (log_addr.size() !== 0) begin fails++; $display("FAIL hit_no_mem: got %0d beats exp 0", log_addr.size()); end
    endtask

    task automatic test_writeback();
        int acc, n0; logic ok;
        logic [31:0] exp_wb [4];
        exp_wb[0] = 32'h1000; exp_wb[1] = 32'h1004; exp_wb[2] = 32'hDEAD_BEEF; exp_wb[3] = 32'h100C;
        clear_log();
        n0 = done_cnt;
        issue(1'b1, 32'h1008, 32'hDEAD_BEEF, acc);
        wait_done(n0, ok);
        checks++; if (ok !== 1'b1 || log_addr.size() !== 0) begin fails++; $display("FAIL wr_hit: got done=%b beats=%0d exp done=1 beats=0", ok, log_addr.size()); end
        n0 = done_cnt;
        issue(1'b0, 32'h2000, 32'h0, acc);
        wait_done(n0, ok);
        checks++; if (done_rdata !== 32'h2000 || log_addr.size() !== 4) begin fails++; $display("FAIL fill2_rdata: got %h beats=%0d exp %h beats=4", done_rdata, log_addr.size(), 32'h2000); end
        clear_log();
        n0 = done_cnt;
        issue(1'b0, 32'h3000, 32'h0, acc);
        wait_done(n0, ok);
        checks++; if (done_rdata !== 32'h3000) begin fails++; $display("FAIL evict_rdata: got %h exp %h", done_rdata, 32'h3000); end
        checks++; if (log_addr.size() !== 8) begin fails++; $display("FAIL evict_beats: got %0d exp 8", log_addr.size()); end
        for (int i = 0; i < 4 && log_addr.size() == 8; i++) begin
            checks++; if (log_we[i] !== 1'b1 || log_addr[i] !== 32'h1000 + 32'(4*i) || log_data[i] !== exp_wb[i]) begin
                fails++; $display("FAIL wb_beat%0d: got we=%b %h=%h exp we=1 %h=%h", i, log_we[i], log_addr[i], log_data[i], 32'h1000 + 32'(4*i), exp_wb[i]);
            end
            checks++; if (log_we[i+4] !== 1'b0 || log_addr[i+4] !== 32'h3000 + 32'(4*i)) begin
                fails++; $display("FAIL evict_refill%0d: got we=%b %h exp we=0 %h", i, log_we[i+4], log_addr[i+4], 32'h3000 + 32'(4*i));
            end
        end
    endtask

    task automatic test_stall();
        int acc, n0; logic ok; logic seen;
        clear_log();
        n0 = done_cnt;
        issue(1'b0, 32'h4000, 32'h0, acc);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            seen = (log_addr.size() >= 2);
        end
        #1 hold = 1'b1;
        checks++; if (seen !== 1'b1) begin fails++; $display("FAIL stall_reach: got %b exp 1", seen); end
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4008 || cpu_done !== 1'b0) begin
                fails++; $display("FAIL stall_hold%0d: got req=%b addr=%h done=%b exp req=1 addr=4008 done=0", i, mem_req, mem_addr, cpu_done);
            end
        end
        @(posedge clk);
        #1 hold = 1'b0;
        wait_done(n0, ok);
        checks++; if (ok !== 1'b1 || done_rdata !== 32'h4000) begin fails++; $display("FAIL stall_rdata: got done=%b %h exp done=1 %h", ok, done_rdata, 32'h4000); end
        checks++; if (log_addr.size() !== 4) begin fails++; $display("FAIL stall_beats: got %0d exp 4", log_addr.size()); end
    endtask

    task automatic test_wb_readback();
        int acc, n0; logic ok;
        clear_log();
        n0 = done_cnt;
        issue(1'b0, 32'h1008, 32'h0, acc);
        wait_done(n0, ok);
        checks++; if (done_rdata !== 32'hDEAD_BEEF || log_addr.size() !== 4) begin
            fails++; $display("FAIL readback: got %h beats=%0d exp deadbeef beats=4", done_rdata, log_addr.size());
        end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats(input int hits, input int misses, input int wbs);
        checks++; if (stat_hits !== 32'(hits))     begin fails++; $display("FAIL stat_hits: got %0d exp %0d", stat_hits, hits); end
        checks++; if (stat_misses !== 32'(misses)) begin fails++; $display("FAIL stat_misses: got %0d exp %0d", stat_misses, misses); end
        checks++; if (stat_wbs !== 32'(wbs))       begin fails++; $display("FAIL stat_wbs: got %0d exp %0d", stat_wbs, wbs); end
    endtask
`endif

    task automatic test_reset_mid_wb();
        int acc, n0; logic ok; logic seen;
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk); reset = 1'b0;
        n0 = done_cnt;
        issue(1'b1, 32'h1000, 32'h1234_5678, acc);
        wait_done(n0, ok);
        n0 = done_cnt;
        issue(1'b0, 32'h2000, 32'h0, acc);
        wait_done(n0, ok);
        clear_log();
        hold = 1'b1;
        n0 = done_cnt;
        issue(1'b0, 32'h3000, 32'h0, acc);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            seen = (mem_req === 1'b1 && mem_we === 1'b1);
        end
        checks++; if (seen !== 1'b1) begin fails++; $display("FAIL midwb_reach: got %b exp 1", seen); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL midwb_abort: got req=%b we=%b exp 0 0", mem_req, mem_we); end
        checks++; if (log_addr.size() !== 0 || done_cnt !== n0) begin fails++; $display("FAIL midwb_quiet: got beats=%0d done=%0d exp 0 0", log_addr.size(), done_cnt - n0); end
        reset = 1'b0;
        hold  = 1'b0;
        clear_log();
        n0 = done_cnt;
        issue(1'b0, 32'h1000, 32'h0, acc);
        wait_done(n0, ok);
        checks++; if (ok !== 1'b1 || done_rdata !== 32'h1000) begin fails++; $display("FAIL midwb_lost: got done=%b %h exp done=1 %h", ok, done_rdata, 32'h1000); end
        checks++; if (log_addr.size() !== 4 || log_addr[0] !== 32'h1000 || log_we[0] !== 1'b0) begin
            fails++; $display("FAIL midwb_miss: got beats=%0d exp 4 refill beats from 1000", log_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_refill_read();
        test_hit();
        test_writeback();
        test_stall();
        test_wb_readback();
`ifdef CACHE_STATS_EN
        test_stats(2, 5, 1);
`endif
        test_reset_mid_wb();
`ifdef CACHE_STATS_EN
        test_stats(0, 1, 0);
`endif
        checks++; if (dbl_done !== 0) begin fails++; $display("FAIL done_consecutive: got %0d exp 0", dbl_done); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
